// File: rtl/serial_adder_arbiter.sv
// Bit-serial adder sharing one full-adder cell between two round-robin arbitrated requesters.
// Operands are summed LSB-first over WIDTH cycles; the result is posted as a one-cycle pulse.
module serial_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic             i_req0_cin,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    input  logic             i_req1_cin,
    output logic             o_req1_ready,
    output logic             o_res_valid,
    output logic [WIDTH-1:0] o_res_sum,
    output logic             o_res_cout,
    output logic             o_res_id,
    output logic             o_busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_cur_id;
    logic             r_last_grant;
    logic             r_busy;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_sum;
    logic             r_res_cout;
    logic             r_res_id;

    logic             w_grant_id;
    logic             w_idle;
    logic             w_accept;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_sum_next;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        w_grant_id = ~i_req0_valid;
        if (i_req0_valid && i_req1_valid) begin
            w_grant_id = ~r_last_grant;
        end
    end

    assign w_idle       = i_rst_n && (r_state == S_IDLE);
    assign o_req0_ready = w_idle && i_req0_valid && !w_grant_id;
    assign o_req1_ready = w_idle && i_req1_valid && w_grant_id;
    assign w_accept     = o_req0_ready || o_req1_ready;

    assign w_fa_sum   = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_fa_cout  = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
    assign w_sum_next = {w_fa_sum, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_sum_sh     <= '0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            r_cur_id     <= 1'b0;
            r_last_grant <= 1'b1;
            r_busy       <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_sum    <= '0;
            r_res_cout   <= 1'b0;
            r_res_id     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_sh       <= w_grant_id ? i_req1_a : i_req0_a;
                        r_b_sh       <= w_grant_id ? i_req1_b : i_req0_b;
                        r_carry      <= w_grant_id ? i_req1_cin : i_req0_cin;
                        r_cur_id     <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_fa_cout;
                    r_cnt    <= r_cnt + CW'(1);
                    // Result registers load with the final bit so they are valid throughout DONE.
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                        r_res_sum   <= w_sum_next;
                        r_res_cout  <= w_fa_cout;
                        r_res_id    <= r_cur_id;
                    end
                end
                S_DONE: begin
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_res_valid = r_res_valid;
    assign o_res_sum   = r_res_sum;
    assign o_res_cout  = r_res_cout;
    assign o_res_id    = r_res_id;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Bench for serial_adder_arbiter: per-cycle check against a transaction-level model,
// plus directed scenarios with literal expected values.
module tb_serial_adder_arbiter;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_cin, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_cin, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic         res_valid, res_cout, res_id, busy;
    logic [W-1:0] res_sum;

    serial_adder_arbiter #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req0_valid (req0_valid),
        .i_req0_a     (req0_a),
        .i_req0_b     (req0_b),
        .i_req0_cin   (req0_cin),
        .o_req0_ready (req0_ready),
        .i_req1_valid (req1_valid),
        .i_req1_a     (req1_a),
        .i_req1_b     (req1_b),
        .i_req1_cin   (req1_cin),
        .o_req1_ready (req1_ready),
        .o_res_valid  (res_valid),
        .o_res_sum    (res_sum),
        .o_res_cout   (res_cout),
        .o_res_id     (res_id),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model: age counts cycles since acceptance (0 = idle).
    bit           m_known = 1'b0;
    int           m_age   = 0;
    bit           m_last  = 1'b1;
    logic [W:0]   m_pend;
    logic         m_pend_id;
    logic [W-1:0] m_hsum  = '0;
    logic         m_hcout = 1'b0;
    logic         m_hid   = 1'b0;

    // Observed DUT events for the directed checks.
    int           acc_c[$];
    bit           acc_id[$];
    int           res_c[$];
    logic [W-1:0] res_s[$];
    logic         res_co[$];
    logic         res_i[$];
    int           n_acc_dut = 0;
    int           n_res_dut = 0;

    always @(negedge clk) begin
        logic e0, e1;
        e0 = rst_n && (m_age == 0) && req0_valid && (!req1_valid || m_last);
        e1 = rst_n && (m_age == 0) && req1_valid && (!req0_valid || !m_last);
        if (m_age == W + 1) begin
            m_hsum  = m_pend[W-1:0];
            m_hcout = m_pend[W];
            m_hid   = m_pend_id;
        end
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("ready_exclusive", req0_ready & req1_ready, 0);
        if (m_known) begin
            chk("res_valid", res_valid, (m_age == W + 1));
            chk("busy", busy, (m_age != 0));
            chk("res_sum", res_sum, m_hsum);
            chk("res_cout", res_cout, m_hcout);
            chk("res_id", res_id, m_hid);
        end
        if (req0_ready && req0_valid) begin acc_c.push_back(cyc); acc_id.push_back(1'b0); n_acc_dut++; end
        if (req1_ready && req1_valid) begin acc_c.push_back(cyc); acc_id.push_back(1'b1); n_acc_dut++; end
        if (res_valid) begin
            res_c.push_back(cyc); res_s.push_back(res_sum);
            res_co.push_back(res_cout); res_i.push_back(res_id);
            n_res_dut++;
        end
        if (!rst_n) begin
            m_known = 1'b1; m_age = 0; m_last = 1'b1;
            m_hsum = '0; m_hcout = 1'b0; m_hid = 1'b0;
        end else if (m_age == 0) begin
            if (e0 || e1) begin
                m_pend_id = e1;
                m_pend = e1 ? ({1'b0, req1_a} + {1'b0, req1_b} + {{W{1'b0}}, req1_cin})
                            : ({1'b0, req0_a} + {1'b0, req0_b} + {{W{1'b0}}, req0_cin});
                m_last = e1;
                m_age  = 1;
            end
        end else begin
            m_age = (m_age == W + 1) ? 0 : m_age + 1;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        acc_c.delete(); acc_id.delete();
        res_c.delete(); res_s.delete(); res_co.delete(); res_i.delete();
    endtask

    task automatic wait_accept(output int c, output bit id);
        c = -1; id = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (acc_c.size() > 0) begin
                c = acc_c.pop_front(); id = acc_id.pop_front();
                return;
            end
        end
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: no acceptance within 40 cycles, required one");
    endtask

    task automatic wait_result(output int c, output logic [W-1:0] s, output logic co, output logic id);
        c = -1; s = '0; co = 1'b0; id = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (res_c.size() > 0) begin
                c = res_c.pop_front(); s = res_s.pop_front();
                co = res_co.pop_front(); id = res_i.pop_front();
                return;
            end
            @(negedge clk); #1;
        end
        n_tests++; n_fail++;
        $display("FAIL result_timeout: no res_valid within 40 cycles, required one");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t, t1, tr;
        bit id;
        logic [W-1:0] s;
        logic co, rid;
        bit a0ok, a1ok;
        int base_acc, base_res;

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 8'hA5; req0_b = 8'h5A; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0;    req1_b = '0;    req1_cin = 1'b0;

        // Reset held two cycles with req0 valid, then basic add A5+5A.
        step();
        @(negedge clk); #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_id", res_id, 0);
        step();
        clear_logs();
        rst_n = 1'b1;
        tr = cyc;
        wait_accept(t, id);
        chk("first_accept_cycle", t, tr);
        chk("first_accept_id", id, 0);
        step();
        req0_valid = 1'b0;
        wait_result(c, s, co, rid);
        chk("basic_latency", c - t, 9);
        chk("basic_sum", s, 8'hFF);
        chk("basic_cout", co, 0);
        chk("basic_id", rid, 0);

        // Back-to-back from req1: overflow then carry-in only.
        step();
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01; req1_cin = 1'b0;
        wait_accept(t1, id);
        chk("b2b_id0", id, 1);
        step();
        req1_a = 8'h00; req1_b = 8'h00; req1_cin = 1'b1;
        wait_accept(t, id);
        chk("b2b_spacing", t - t1, 10);
        step();
        req1_valid = 1'b0;
        wait_result(c, s, co, rid);
        chk("ovf_sum", s, 8'h00);
        chk("ovf_cout", co, 1);
        chk("ovf_id", rid, 1);
        wait_result(c, s, co, rid);
        chk("cin_sum", s, 8'h01);
        chk("cin_cout", co, 0);
        chk("cin_id", rid, 1);

        // Request from req1 arriving while req0's operation runs.
        step();
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_cin = 1'b0;
        wait_accept(t, id);
        chk("run_req0_id", id, 0);
        step(); req0_valid = 1'b0;
        step();
        step();
        req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h80; req1_cin = 1'b1;
        wait_accept(t1, id);
        chk("run_req1_cycle", t1 - t, 10);
        chk("run_req1_id", id, 1);
        step(); req1_valid = 1'b0;
        wait_result(c, s, co, rid);
        chk("run_sum0", s, 8'h46);
        chk("run_id0", rid, 0);
        wait_result(c, s, co, rid);
        chk("run_sum1", s, 8'h01);
        chk("run_cout1", co, 1);
        chk("run_id1", rid, 1);

        // Reset mid-operation, then contention after reset.
        step();
        clear_logs();
        req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'hF0; req0_cin = 1'b1;
        wait_accept(t, id);
        step(); req0_valid = 1'b0;
        step();
        step();
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        @(negedge clk); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_res_valid", res_valid, 0);
        clear_logs();
        repeat (15) step();
        chk("midrst_no_result", res_c.size(), 0);

        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h04; req1_cin = 1'b0;
        t1 = -1;
        for (int i = 0; i < 4; i++) begin
            wait_accept(t, id);
            chk("tie_grant", id, i % 2);
            if (i > 0) chk("tie_spacing", t - t1, W + 2);
            t1 = t;
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_result(c, s, co, rid);
            chk("tie_res_id", rid, i % 2);
            chk("tie_res_sum", s, (i % 2 == 0) ? 8'h03 : 8'h07);
        end

        // Random traffic; the per-cycle model checks every result.
        step();
        base_acc = n_acc_dut;
        base_res = n_res_dut;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            a0ok = req0_valid && req0_ready;
            a1ok = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (a0ok || !req0_valid) begin
                req0_valid = 1'($urandom_range(1, 0));
                req0_a = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
                req0_b = 8'($urandom);
                req0_cin = 1'($urandom_range(1, 0));
            end else if ($urandom_range(15, 0) == 0) begin
                req0_valid = 1'b0;
            end
            if (a1ok || !req1_valid) begin
                req1_valid = 1'($urandom_range(1, 0));
                req1_a = 8'($urandom);
                req1_b = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
                req1_cin = 1'($urandom_range(1, 0));
            end else if ($urandom_range(15, 0) == 0) begin
                req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2 * (W + 2)) step();
        chk("rand_one_result_per_accept", n_res_dut - base_res, n_acc_dut - base_acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
